// File: rtl/svc_rv_io_arb_pkg.sv
// Shared types for the two-requester I/O arbiter: lock FSM states and
// the requester identifier used for grants and read ownership.
package svc_rv_io_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_M0) ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/svc_rv_io_arb_rr.sv
// Two-way round-robin grant selection with a priority pointer that only
// moves when a grant is issued (every grant is an accepted beat).
module svc_rv_io_arb_rr
    import svc_rv_io_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_req0,
    input  logic   i_req1,
    output logic   o_gnt_vld,
    output owner_t o_gnt
);

    owner_t r_prio;

    always_comb begin
        o_gnt_vld = i_req0 || i_req1;
        if (i_req0 && i_req1) begin
            o_gnt = r_prio;
        end else if (i_req1) begin
            o_gnt = OWN_M1;
        end else begin
            o_gnt = OWN_M0;
        end
    end

    // The loser of the latest grant is favoured next time both compete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= OWN_M0;
        end else if (o_gnt_vld) begin
            r_prio <= other_owner(o_gnt);
        end
    end

endmodule

// File: rtl/svc_rv_io_arb.sv
// Arbitrates two valid/ready requesters onto a 1-cycle-latency BRAM port.
// Bus locking is compiled in only when SVC_RV_IO_ARB_LOCK_EN is defined.
module svc_rv_io_arb
    import svc_rv_io_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_valid,
    output logic            m0_ready,
    input  logic            m0_write,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    input  logic            m0_lock,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,

    input  logic            m1_valid,
    output logic            m1_ready,
    input  logic            m1_write,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    input  logic            m1_lock,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,

    output logic            io_ren,
    output logic [AW-1:0]   io_raddr,
    input  logic [DW-1:0]   io_rdata,
    output logic            io_wen,
    output logic [AW-1:0]   io_waddr,
    output logic [DW-1:0]   io_wdata,
    output logic [DW/8-1:0] io_wstrb
);

    arb_state_t      r_state;
    logic            r_rd_pend;
    owner_t          r_rd_owner;

    logic            w_req0;
    logic            w_req1;
    logic            w_gnt_vld;
    owner_t          w_gnt;
    logic            w_sel_write;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic [DW/8-1:0] w_sel_wstrb;

    // Handshake: a beat transfers on a cycle where mN_valid && mN_ready;
    // ready rises only for the granted requester while its valid is high,
    // and a requester that is not granted keeps its beat presented.
    assign w_req0 = m0_valid && !rst && (r_state != LOCK1);
    assign w_req1 = m1_valid && !rst && (r_state != LOCK0);

    svc_rv_io_arb_rr u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req0    (w_req0),
        .i_req1    (w_req1),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt     (w_gnt)
    );

    assign m0_ready = w_gnt_vld && (w_gnt == OWN_M0);
    assign m1_ready = w_gnt_vld && (w_gnt == OWN_M1);

    assign w_sel_write = (w_gnt == OWN_M1) ? m1_write : m0_write;
    assign w_sel_addr  = (w_gnt == OWN_M1) ? m1_addr  : m0_addr;
    assign w_sel_wdata = (w_gnt == OWN_M1) ? m1_wdata : m0_wdata;
    assign w_sel_wstrb = (w_gnt == OWN_M1) ? m1_wstrb : m0_wstrb;

    assign io_wen   = w_gnt_vld && w_sel_write;
    assign io_ren   = w_gnt_vld && !w_sel_write;
    assign io_waddr = io_wen ? w_sel_addr  : '0;
    assign io_wdata = io_wen ? w_sel_wdata : '0;
    assign io_wstrb = io_wen ? w_sel_wstrb : '0;
    assign io_raddr = io_ren ? w_sel_addr  : '0;

    // BRAM data lands one cycle after the read beat; route it to its owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= OWN_M0;
        end else begin
            r_rd_pend  <= io_ren;
            r_rd_owner <= w_gnt;
        end
    end

    assign m0_rvalid = r_rd_pend && (r_rd_owner == OWN_M0);
    assign m1_rvalid = r_rd_pend && (r_rd_owner == OWN_M1);
    assign m0_rdata  = m0_rvalid ? io_rdata : '0;
    assign m1_rdata  = m1_rvalid ? io_rdata : '0;

`ifdef SVC_RV_IO_ARB_LOCK_EN
    logic w_sel_lock;
    assign w_sel_lock = (w_gnt == OWN_M1) ? m1_lock : m0_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB;
        end else if (w_gnt_vld) begin
            case (r_state)
                ARB:          if (w_sel_lock) r_state <= (w_gnt == OWN_M1) ? LOCK1 : LOCK0;
                LOCK0, LOCK1: if (!w_sel_lock) r_state <= ARB;
                default:      r_state <= ARB;
            endcase
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = m0_lock ^ m1_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB;
        end else begin
            r_state <= ARB;
        end
    end
`endif

endmodule

// File: tb/tb_svc_rv_io_arb.sv
// Directed bench for svc_rv_io_arb: BRAM environment, per-cycle model compare,
// and literal expectations for the key scenarios (lock or plain build).
module tb_svc_rv_io_arb;

  logic        clk;
  logic        rst;
  logic        m0_valid, m0_ready, m0_write, m0_lock, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_ready, m1_write, m1_lock, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        io_ren, io_wen;
  logic [31:0] io_raddr, io_rdata, io_waddr, io_wdata;
  logic [3:0]  io_wstrb;

  int tests = 0;
  int fails = 0;

  svc_rv_io_arb #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_lock(m0_lock),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_lock(m1_lock),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .io_ren(io_ren), .io_raddr(io_raddr), .io_rdata(io_rdata),
    .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wstrb(io_wstrb)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- BRAM environment (1-cycle read latency) ----------------
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (io_wen) begin
      for (int b = 0; b < 4; b++)
        if (io_wstrb[b]) mem[io_waddr[5:2]][8*b +: 8] <= io_wdata[8*b +: 8];
    end
    if (io_ren) io_rdata <= mem[io_raddr[5:2]];
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
    m0_valid = 1'b0; m0_lock = 1'b0;
    m1_valid = 1'b0; m1_lock = 1'b0;
  endtask

  task automatic req(input int n, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic lk);
    if (n == 0) begin
      m0_valid = 1'b1; m0_write = wr; m0_addr = a; m0_wdata = d; m0_wstrb = s; m0_lock = lk;
    end else begin
      m1_valid = 1'b1; m1_write = wr; m1_addr = a; m1_wdata = d; m1_wstrb = s; m1_lock = lk;
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [31:0] shadow [16];
  logic [32:0] exp_q [$];   // {owner, data} of reads awaiting return
  int          prefer;      // requester that wins a tie
  int          lock_owner;  // -1 when unlocked
  int          g;
  int          cands [$];
  logic        vv [2], ww [2], ll [2];
  logic [31:0] aa [2], dd [2];
  logic [3:0]  ss [2];
  logic [32:0] e;
  logic        e_rv0, e_rv1;
  logic [31:0] e_rd0, e_rd1;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      check("rst_m0_ready", m0_ready, 0);   check("rst_m1_ready", m1_ready, 0);
      check("rst_m0_rvalid", m0_rvalid, 0); check("rst_m1_rvalid", m1_rvalid, 0);
      check("rst_m0_rdata", m0_rdata, 0);   check("rst_m1_rdata", m1_rdata, 0);
      check("rst_io_ren", io_ren, 0);       check("rst_io_wen", io_wen, 0);
      check("rst_io_raddr", io_raddr, 0);   check("rst_io_waddr", io_waddr, 0);
      check("rst_io_wdata", io_wdata, 0);   check("rst_io_wstrb", io_wstrb, 0);
      exp_q.delete();
      prefer = 0;
      lock_owner = -1;
    end else begin
      e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[32]) begin e_rv1 = 1'b1; e_rd1 = e[31:0]; end
        else       begin e_rv0 = 1'b1; e_rd0 = e[31:0]; end
      end
      check("m0_rvalid", m0_rvalid, e_rv0); check("m1_rvalid", m1_rvalid, e_rv1);
      check("m0_rdata", m0_rdata, e_rd0);   check("m1_rdata", m1_rdata, e_rd1);

      vv[0] = m0_valid; ww[0] = m0_write; ll[0] = m0_lock; aa[0] = m0_addr; dd[0] = m0_wdata; ss[0] = m0_wstrb;
      vv[1] = m1_valid; ww[1] = m1_write; ll[1] = m1_lock; aa[1] = m1_addr; dd[1] = m1_wdata; ss[1] = m1_wstrb;
      cands = {};
      for (int n = 0; n < 2; n++)
        if (vv[n] && (lock_owner < 0 || lock_owner == n)) cands.push_back(n);
      if (cands.size() == 0)      g = -1;
      else if (cands.size() == 1) g = cands[0];
      else                        g = prefer;

      check("m0_ready", m0_ready, g == 0);
      check("m1_ready", m1_ready, g == 1);
      if (g >= 0 && ww[g]) begin
        check("io_wen", io_wen, 1);        check("io_ren", io_ren, 0);
        check("io_waddr", io_waddr, aa[g]); check("io_wdata", io_wdata, dd[g]);
        check("io_wstrb", io_wstrb, ss[g]);
        for (int b = 0; b < 4; b++)
          if (ss[g][b]) shadow[aa[g][5:2]][8*b +: 8] = dd[g][8*b +: 8];
      end else if (g >= 0) begin
        check("io_ren", io_ren, 1);        check("io_wen", io_wen, 0);
        check("io_raddr", io_raddr, aa[g]);
        exp_q.push_back({(g == 1), shadow[aa[g][5:2]]});
      end else begin
        check("idle_io_ren", io_ren, 0);   check("idle_io_wen", io_wen, 0);
      end
      if (g >= 0) begin
        prefer = 1 - g;
`ifdef SVC_RV_IO_ARB_LOCK_EN
        lock_owner = ll[g] ? g : -1;
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] lock_exp_rdy0;
  logic [31:0] ra;

  initial begin
    rst = 1'b1;
    m0_valid = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0; m0_lock = 0;
    m1_valid = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0; m1_lock = 0;
    io_rdata = '0;
    prefer = 0; lock_owner = -1;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
      shadow[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    end

    // reset: a valid request must not be granted while rst is high
    next_cycle(); req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    #3 check("lit_rst_ready", m0_ready, 0); check("lit_rst_ren", io_ren, 0);
    next_cycle();
    next_cycle(); rst = 1'b0;

    // m0 write, m1 read back
    next_cycle(); req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    #3 check("lit_wr_m0_ready", m0_ready, 1);
    next_cycle(); req(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    #3 check("lit_rd_m1_ready", m1_ready, 1);
    next_cycle();
    #3 check("lit_m1_rvalid", m1_rvalid, 1); check("lit_m1_rdata", m1_rdata, 32'hDEADBEEF);
    check("lit_m0_rvalid_quiet", m0_rvalid, 0);

    // both reading: grants alternate m0,m1,m0,m1
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      req(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
      #3 check("lit_alt_m0_ready", m0_ready, (c % 2) == 0);
      if (c > 0) begin
        check("lit_alt_rvalid_m0", m0_rvalid, (c % 2) == 1);
        check("lit_alt_rvalid_m1", m1_rvalid, (c % 2) == 0);
      end
    end
    next_cycle();
    #3 check("lit_alt_last_m1_rvalid", m1_rvalid, 1);
    check("lit_alt_last_m1_rdata", m1_rdata, 32'h1000_0101);

    // partial-strobe write over a full word
    next_cycle(); req(1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 1'b0);
    next_cycle(); req(1, 1'b1, 32'h8, 32'h00001234, 4'h3, 1'b0);
    next_cycle(); req(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
    next_cycle();
    #3 check("lit_strb_rvalid", m1_rvalid, 1); check("lit_strb_rdata", m1_rdata, 32'hFFFF1234);

    // lock: make m1 favoured, then m1 issues lock=1,1,0 while m0 stays valid
    next_cycle(); req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
`ifdef SVC_RV_IO_ARB_LOCK_EN
    lock_exp_rdy0 = 4'b1000;
`else
    lock_exp_rdy0 = 4'b1010;
`endif
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      req(1, 1'b1, 32'h20, 32'hC0DE_0000 + 32'(c), 4'hF, (c < 2));
      #3 check("lit_lock_m0_ready", m0_ready, lock_exp_rdy0[c]);
    end

    // mixed traffic without lock
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      for (int n = 0; n < 2; n++)
        if ($urandom_range(0, 1) == 1) begin
          ra = 32'($urandom_range(0, 15)) << 2;
          req(n, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), 1'b0);
        end
    end
    next_cycle();

    // reset right after an accepted read: its return is dropped
    next_cycle(); req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    #3 check("lit_pre_rst_ready", m0_ready, 1);
    next_cycle(); rst = 1'b1; req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    #3 check("lit_mid_rst_rvalid", m0_rvalid, 0); check("lit_mid_rst_ready", m0_ready, 0);
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    #3 check("lit_post_rst_rv0", m0_rvalid, 0); check("lit_post_rst_rv1", m1_rvalid, 0);
    next_cycle();
    req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    req(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    #3 check("lit_post_rst_m0_gnt", m0_ready, 1); check("lit_post_rst_m1_gnt", m1_ready, 0);
    next_cycle();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/svc_rv_io_arb.md
SVC_RV_IO_ARB -- requirements
Module: svc_rv_io_arb

Interface
REQ-001 SHALL have parameter AW, default 32, the byte address width.
REQ-002 SHALL have parameter DW, default 32, the data width; the strobe width is DW/8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have, for each requester n in {0,1}, these ports:
- mN_valid, input, 1 bit
- mN_ready, output, 1 bit
- mN_write, input, 1 bit
- mN_addr, input, AW bits
- mN_wdata, input, DW bits
- mN_wstrb, input, DW/8 bits
- mN_lock, input, 1 bit
- mN_rvalid, output, 1 bit
- mN_rdata, output, DW bits
REQ-006 SHALL have these memory-side ports, matching the 1-cycle-latency BRAM:
- io_ren, output, 1 bit
- io_raddr, output, AW bits
- io_rdata, input, DW bits
- io_wen, output, 1 bit
- io_waddr, output, AW bits
- io_wdata, output, DW bits
- io_wstrb, output, DW/8 bits

Function
REQ-007 SHALL accept at most one beat per cycle; a beat on requester n is accepted when mN_valid and mN_ready are both high.
REQ-008 SHALL assert mN_ready combinationally only for the granted requester, and only when mN_valid is high.
REQ-009 SHALL grant as follows when unlocked:
- if only one requester is valid, grant it;
- if both are valid, grant the requester not granted last (round-robin);
- after reset, the priority pointer favours m0.
REQ-010 SHALL drive the memory port on the same cycle as the accepted beat:
- write beat: io_wen=1, with io_waddr, io_wdata and io_wstrb taken from the winner;
- read beat: io_ren=1, with io_raddr taken from the winner;
- both strobes are 0 on any cycle with no accepted beat.
REQ-011 SHALL register the owner of each accepted read, then one cycle later pulse mN_rvalid for exactly one cycle to that owner, with mN_rdata=io_rdata.
REQ-012 SHALL let back-to-back reads from alternating requesters each return in order, one cycle after acceptance, with no bubble.
REQ-013 SHALL complete writes on acceptance; writes produce no mN_rvalid.
REQ-014 SHALL implement a state machine with states ARB, LOCK0 and LOCK1:
- ARB to LOCKn: on an accepted beat from mN with mN_lock=1;
- LOCKn to ARB: on an accepted beat from mN with mN_lock=0;
- in LOCKn only requester n can be granted, even when the other requester is valid.
REQ-015 SHALL update the round-robin pointer only on accepted beats, so that idle cycles do not change priority.
REQ-016 SHALL drive mN_rdata with 0 whenever mN_rvalid is low.

Reset
REQ-017 SHALL, while rst is high, force the following regardless of clk:
- state=ARB, priority pointer favours m0;
- pending-read flag and owner cleared;
- all outputs (ready, rvalid, rdata, io_ren, io_wen) 0; io address/data outputs 0.
REQ-018 SHALL discard any read accepted on the cycle before rst asserts mid-operation; no rvalid is emitted after reset deasserts.

Configuration
REQ-019 SHALL compile the lock feature only when SVC_RV_IO_ARB_LOCK_EN is defined; undefined: mN_lock ports are present but ignored, and state stays ARB (pure round-robin).

Structure
REQ-020 SHALL place the state enum (ARB, LOCK0, LOCK1) and the owner typedef in package svc_rv_io_arb_pkg.
REQ-021 SHALL implement grant selection plus the pointer in sub-module svc_rv_io_arb_rr (2-way round-robin); pipeline tracking and muxing stay in the top module.

Verification
REQ-022 SHALL cover these directed scenarios:
- m0 writes 0xDEADBEEF to 0x10 with wstrb 0xF, then m1 reads 0x10 -> m1_rvalid one cycle after acceptance, m1_rdata=0xDEADBEEF, m0_rvalid stays 0.
- both valid reading 0x0 and 0x4 for 4 cycles -> grants alternate m0,m1,m0,m1, each rvalid routed to the correct owner.
- m1 writes 0x1234 to 0x8 with wstrb 0x3 over existing 0xFFFFFFFF -> a later read returns 0xFFFF1234.
- with SVC_RV_IO_ARB_LOCK_EN defined, m1 issues 3 beats with lock=1,1,0 while m0 stays valid -> m0_ready=0 for those 3 cycles, m0 granted on the 4th.
- without the macro, the same stimulus -> grants alternate and the lock is ignored.
- rst asserted the cycle after a read is accepted -> no rvalid after release; first grant goes to m0 when both requesters are valid.
